// File: rtl/obuffer_sg_tx.sv
// rtl/obuffer_sg_tx.sv - Stop & Go link transmitter: flit FIFO, phit serializer, registered link outputs
module obuffer_sg_tx #(
  parameter int FLIT_SIZE      = 64,
  parameter int PHIT_SIZE      = 64,
  parameter int FLIT_TYPE_SIZE = 2,
  parameter int QUEUE_SIZE     = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [FLIT_SIZE-1:0]      FlitIn,
  input  logic [FLIT_TYPE_SIZE-1:0] FlitTypeIn,
  input  logic                      BroadcastFlitIn,
  input  logic                      ValidIn,
  output logic                      Avail,
  output logic [PHIT_SIZE-1:0]      Flit,
  output logic [FLIT_TYPE_SIZE-1:0] FlitType,
  output logic                      BroadcastFlit,
  output logic                      Valid,
  input  logic                      Go,
  output logic                      Busy
);

  localparam int NUM_PHITS = FLIT_SIZE / PHIT_SIZE;
  localparam int LAST_PHIT = NUM_PHITS - 1;
  localparam int PTR_W     = $clog2(QUEUE_SIZE);
  localparam int CNT_W     = PTR_W + 1;
  localparam int PC_W      = (NUM_PHITS > 1) ? $clog2(NUM_PHITS) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  logic [FLIT_SIZE-1:0]      q_flit  [QUEUE_SIZE];
  logic [FLIT_TYPE_SIZE-1:0] q_type  [QUEUE_SIZE];
  logic                      q_bcast [QUEUE_SIZE];

  logic [PTR_W-1:0] read_ptr, write_ptr;
  logic [CNT_W-1:0] count;
  state_t           state, state_nxt;
  logic [PC_W-1:0]  phit_cnt, phit_cnt_nxt;
  logic [PC_W-1:0]  load_idx;
  logic             load, pop, push;
  logic [FLIT_SIZE-1:0] head_flit;
  logic [PHIT_SIZE-1:0] phit_sel;

  assign Avail     = rst_n & (count < CNT_W'(QUEUE_SIZE));
  assign push      = ValidIn & Avail;
  assign Busy      = (count != '0) | (state == SEND);
  assign head_flit = q_flit[read_ptr];

  // Phit 0 is the LSB slice so the receiver reassembles in arrival order.
  always_comb begin
    phit_sel = '0;
    for (int k = 0; k < NUM_PHITS; k++) begin
      if (load_idx == PC_W'(k)) phit_sel = head_flit[k*PHIT_SIZE +: PHIT_SIZE];
    end
  end

  // SEND's last phit always returns to IDLE; IDLE then decides on the next
  // flit in the very next cycle, so back-to-back flits have no dead cycle.
  always_comb begin
    state_nxt    = state;
    phit_cnt_nxt = phit_cnt;
    load         = 1'b0;
    load_idx     = '0;
    pop          = 1'b0;
    case (state)
      IDLE: begin
        if ((count != '0) && Go) begin
          load = 1'b1;
          if (NUM_PHITS == 1) begin
            pop = 1'b1;
          end else begin
            phit_cnt_nxt = PC_W'(1);
            state_nxt    = SEND;
          end
        end
      end
      SEND: begin
        load     = 1'b1;
        load_idx = phit_cnt;
        if (phit_cnt == PC_W'(LAST_PHIT)) begin
          pop          = 1'b1;
          phit_cnt_nxt = '0;
          state_nxt    = IDLE;
        end else begin
          phit_cnt_nxt = phit_cnt + PC_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_flit[write_ptr]  <= FlitIn;
      q_type[write_ptr]  <= FlitTypeIn;
      q_bcast[write_ptr] <= BroadcastFlitIn;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_ptr      <= '0;
      write_ptr     <= '0;
      count         <= '0;
      state         <= IDLE;
      phit_cnt      <= '0;
      Flit          <= '0;
      FlitType      <= '0;
      BroadcastFlit <= 1'b0;
      Valid         <= 1'b0;
    end else begin
      state    <= state_nxt;
      phit_cnt <= phit_cnt_nxt;
      if (push) write_ptr <= write_ptr + PTR_W'(1);
      if (pop)  read_ptr  <= read_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      Valid <= load;
      if (load) begin
        Flit          <= phit_sel;
        FlitType      <= q_type[read_ptr];
        BroadcastFlit <= q_bcast[read_ptr];
      end
    end
  end

endmodule

// File: tb/tb_obuffer_sg_tx.sv
// tb/tb_obuffer_sg_tx.sv - scoreboard bench for obuffer_sg_tx (64/64 and 64/16 phit instances)
module tb_obuffer_sg_tx;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [63:0] a_flit_in, a_flit;
  logic [1:0]  a_type_in, a_type;
  logic        a_bc_in, a_valid_in, a_avail, a_bc, a_valid, a_go, a_busy;

  logic [63:0] b_flit_in;
  logic [15:0] b_flit;
  logic [1:0]  b_type_in, b_type;
  logic        b_bc_in, b_valid_in, b_avail, b_bc, b_valid, b_go, b_busy;

  obuffer_sg_tx #(.FLIT_SIZE(64), .PHIT_SIZE(64), .FLIT_TYPE_SIZE(2), .QUEUE_SIZE(4)) u_a (
    .clk(clk), .rst_n(rst_n), .FlitIn(a_flit_in), .FlitTypeIn(a_type_in),
    .BroadcastFlitIn(a_bc_in), .ValidIn(a_valid_in), .Avail(a_avail), .Flit(a_flit),
    .FlitType(a_type), .BroadcastFlit(a_bc), .Valid(a_valid), .Go(a_go), .Busy(a_busy)
  );

  obuffer_sg_tx #(.FLIT_SIZE(64), .PHIT_SIZE(16), .FLIT_TYPE_SIZE(2), .QUEUE_SIZE(4)) u_b (
    .clk(clk), .rst_n(rst_n), .FlitIn(b_flit_in), .FlitTypeIn(b_type_in),
    .BroadcastFlitIn(b_bc_in), .ValidIn(b_valid_in), .Avail(b_avail), .Flit(b_flit),
    .FlitType(b_type), .BroadcastFlit(b_bc), .Valid(b_valid), .Go(b_go), .Busy(b_busy)
  );

  int total = 0;
  int bad   = 0;

  // scoreboard entry: {broadcast, type, phit (zero-extended to 64)}
  logic [66:0] sb_a[$];
  logic [66:0] sb_b[$];
  logic [66:0] ea, eb;
  int          idx;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic sb_b_flit(input logic [63:0] d, input logic [1:0] t, input logic b);
    for (int k = 0; k < 4; k++) sb_b.push_back({b, t, 48'h0, d[k*16 +: 16]});
  endtask

  always @(negedge clk) begin
    if (rst_n && a_valid) begin
      if (sb_a.size() == 0) check("a_unexpected_phit", a_flit, 64'h0);
      else begin
        ea = sb_a.pop_front();
        check("a_phit", a_flit, ea[63:0]);
        check("a_type", 64'(a_type), 64'(ea[65:64]));
        check("a_bcast", 64'(a_bc), 64'(ea[66]));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_valid) begin
      if (sb_b.size() == 0) check("b_unexpected_phit", 64'(b_flit), 64'h0);
      else begin
        eb = sb_b.pop_front();
        check("b_phit", 64'(b_flit), eb[63:0]);
        check("b_type", 64'(b_type), 64'(eb[65:64]));
        check("b_bcast", 64'(b_bc), 64'(eb[66]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    a_flit_in = '0; a_type_in = '0; a_bc_in = 1'b0; a_valid_in = 1'b0; a_go = 1'b1;
    b_flit_in = '0; b_type_in = '0; b_bc_in = 1'b0; b_valid_in = 1'b0; b_go = 1'b1;

    // reset state
    @(negedge clk);
    check("rst_a_valid", 64'(a_valid), 64'h0);
    check("rst_a_avail", 64'(a_avail), 64'h0);
    check("rst_a_busy",  64'(a_busy),  64'h0);
    check("rst_b_flit",  64'(b_flit),  64'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("rel_a_avail", 64'(a_avail), 64'h1);
    check("rel_b_avail", 64'(b_avail), 64'h1);
    @(posedge clk); #1;

    // 1: three back-to-back full-width flits, latency 2, no bubbles
    for (int i = 0; i < 6; i++) begin
      a_valid_in = (i < 3);
      if (i < 3) begin
        a_flit_in = {16{4'(i + 1)}};
        a_type_in = 2'(i + 1);
        a_bc_in   = (i == 1);
        sb_a.push_back({a_bc_in, a_type_in, a_flit_in});
      end
      @(negedge clk);
      check("t1_valid", 64'(a_valid), 64'((i >= 2) && (i < 5)));
      @(posedge clk); #1;
    end
    check("t1_busy", 64'(a_busy), 64'h0);

    // 2: one flit split into four 16-bit phits, LSB first
    for (int i = 0; i < 7; i++) begin
      b_valid_in = (i == 0);
      if (i == 0) begin
        b_flit_in = 64'hDDDD_CCCC_BBBB_AAAA; b_type_in = 2'd2; b_bc_in = 1'b1;
        sb_b_flit(b_flit_in, b_type_in, b_bc_in);
      end
      @(negedge clk);
      check("t2_valid", 64'(b_valid), 64'((i >= 2) && (i <= 5)));
      @(posedge clk); #1;
    end

    // 3: Go drops during phit 1 of A; A completes, B waits for Go
    for (int i = 0; i < 15; i++) begin
      b_valid_in = (i < 2);
      b_go = !((i >= 3) && (i <= 8));
      if (i == 0) begin
        b_flit_in = 64'h0A03_0A02_0A01_0A00; b_type_in = 2'd1; b_bc_in = 1'b0;
        sb_b_flit(b_flit_in, b_type_in, b_bc_in);
      end else if (i == 1) begin
        b_flit_in = 64'h0B03_0B02_0B01_0B00; b_type_in = 2'd3; b_bc_in = 1'b1;
        sb_b_flit(b_flit_in, b_type_in, b_bc_in);
      end
      @(negedge clk);
      check("t3_valid", 64'(b_valid), 64'(((i >= 2) && (i <= 5)) || ((i >= 10) && (i <= 13))));
      @(posedge clk); #1;
    end

    // 4: Go low, five pushes into a 4-deep FIFO; fifth is dropped
    b_go = 1'b0;
    for (int i = 0; i < 5; i++) begin
      b_flit_in = {16'h4400, 32'h0, 16'(i)}; b_type_in = 2'(i); b_bc_in = i[0];
      b_valid_in = 1'b1;
      @(negedge clk);
      check("t4_avail_fill", 64'(b_avail), 64'(i < 4));
      if (i < 4) sb_b_flit(b_flit_in, b_type_in, b_bc_in);
      @(posedge clk); #1;
    end
    b_valid_in = 1'b0;
    @(negedge clk);
    check("t4_full_avail", 64'(b_avail), 64'h0);
    check("t4_full_busy",  64'(b_busy),  64'h1);
    check("t4_stopped",    64'(b_valid), 64'h0);
    @(posedge clk); #1 b_go = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      check("t4_avail_pop", 64'(b_avail), 64'(j >= 4));
      @(posedge clk); #1;
    end
    for (int n = 0; n < 40 && sb_b.size() != 0; n++) @(posedge clk);
    repeat (3) @(negedge clk);
    check("t4_drained", 64'(sb_b.size()), 64'h0);
    check("t4_idle_busy", 64'(b_busy), 64'h0);
    @(posedge clk); #1;

    // 5: full FIFO then streaming with Go=1: simultaneous push/pop, pointer wrap
    a_go = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_flit_in = {8{8'h60 + 8'(i)}}; a_type_in = 2'(i); a_bc_in = i[0]; a_valid_in = 1'b1;
      sb_a.push_back({a_bc_in, a_type_in, a_flit_in});
      @(posedge clk); #1;
    end
    a_valid_in = 1'b0;
    @(negedge clk);
    check("t5_full_avail", 64'(a_avail), 64'h0);
    @(posedge clk); #1 a_go = 1'b1;
    idx = 0;
    for (int n = 0; n < 40 && idx < 4; n++) begin
      a_flit_in = {8{8'h70 + 8'(idx)}}; a_type_in = 2'(idx + 1); a_bc_in = !idx[0];
      a_valid_in = 1'b1;
      @(negedge clk);
      if (a_avail) begin
        sb_a.push_back({a_bc_in, a_type_in, a_flit_in});
        idx++;
      end
      @(posedge clk); #1;
    end
    a_valid_in = 1'b0;
    check("t5_pushed", 64'(idx), 64'd4);
    for (int n = 0; n < 40 && sb_a.size() != 0; n++) @(posedge clk);
    repeat (2) @(negedge clk);
    check("t5_drained", 64'(sb_a.size()), 64'h0);
    check("t5_busy", 64'(a_busy), 64'h0);
    @(posedge clk); #1;

    // 6: asynchronous reset during phit 2 aborts the flit
    for (int i = 0; i < 4; i++) begin
      b_valid_in = (i < 2);
      if (i < 2) begin
        b_flit_in = {4{8'h90 + 8'(i), 8'h00 + 8'(i)}}; b_type_in = 2'd1; b_bc_in = 1'b0;
        sb_b_flit(b_flit_in, b_type_in, b_bc_in);
      end
      @(negedge clk);
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    check("t6_valid", 64'(b_valid), 64'h0);
    check("t6_flit",  64'(b_flit),  64'h0);
    check("t6_busy",  64'(b_busy),  64'h0);
    check("t6_avail", 64'(b_avail), 64'h0);
    sb_b.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("t6_avail_rel", 64'(b_avail), 64'h1);
    @(posedge clk); #1;
    for (int i = 0; i < 7; i++) begin
      b_valid_in = (i == 0);
      if (i == 0) begin
        b_flit_in = 64'h4444_3333_2222_1111; b_type_in = 2'd3; b_bc_in = 1'b1;
        sb_b_flit(b_flit_in, b_type_in, b_bc_in);
      end
      @(negedge clk);
      check("t6_valid_after", 64'(b_valid), 64'((i >= 2) && (i <= 5)));
      @(posedge clk); #1;
    end

    check("end_sb_a", 64'(sb_a.size()), 64'h0);
    check("end_sb_b", 64'(sb_b.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
